dcache_lookup_ctrl: RTL and testbench



---
 rtl/dcache_lookup_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dcache_lookup_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_lookup_ctrl.sv
// dcache_lookup_ctrl
// L1 data-cache lookup and miss controller sitting in front of the tag array.
// Accepts one address at a time and drives the tag array index. It compares
// every way's returned tag to detect a hit. On a miss it picks a victim and
// requests a line refill. When the refill completes it writes the new tag,
// then responds.
//
// Build option:
//   DCACHE_PLRU_EN  defined   -> per-set tree pseudo-LRU (NUM_WAYS-1 bits/set)
//                   undefined -> one global round-robin victim counter
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_addr = byte address
//   rsp_valid/rsp_hit/rsp_way  one-cycle response pulse, hit flag, way
//   ta_index                   tag array set index (held LOOKUP..FILL)
//   ta_we/ta_way/ta_tag_in     tag array write port (FILL only)
//   ta_tag_out/ta_valid_out    per-way tag/valid, combinational read
//   refill_req_valid/ready     refill request handshake to next level
//   refill_req_addr            line-aligned refill address
//   refill_done                refill completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | ready for a request
// LOOKUP    | compare tag array outputs, choose hit way/victim
// MISS_REQ  | hold refill request until next level accepts
// MISS_WAIT | wait for refill_done
// FILL      | write new tag, mark way locally valid
// RESP      | one-cycle response pulse
module dcache_lookup_ctrl #(
  parameter int TAG_W    = 20,
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         rsp_valid,
  output logic                         rsp_hit,
  output logic [$clog2(NUM_WAYS)-1:0]  rsp_way,
  output logic [$clog2(NUM_SETS)-1:0]  ta_index,
  output logic [$clog2(NUM_WAYS)-1:0]  ta_way,
  output logic [TAG_W-1:0]             ta_tag_in,
  output logic                         ta_we,
  input  logic [NUM_WAYS*TAG_W-1:0]    ta_tag_out,
  input  logic [NUM_WAYS-1:0]          ta_valid_out,
  output logic                         refill_req_valid,
  input  logic                         refill_req_ready,
  output logic [ADDR_W-1:0]            refill_req_addr,
  input  logic                         refill_done
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int OFF_W = ADDR_W - TAG_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_REQ  = 3'd2,
    S_MISS_WAIT = 3'd3,
    S_FILL      = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [WAY_W-1:0] way_q;
  logic             hit_q;

  // Local valid bitmap: the tag array's valid bits are not reset, so a line
  // only counts once this controller has filled it since the last reset.
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] lvalid;

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             free_any;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] pol_way;
  logic [WAY_W-1:0] victim;

  logic unused_offset;
  assign unused_offset = ^req_addr[OFF_W-1:0];

  // Hit detection; scanning high to low leaves the lowest hitting way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (lvalid[idx_q][w] && ta_valid_out[w] &&
          (ta_tag_out[w*TAG_W +: TAG_W] == tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest way not yet filled in this set takes priority over the policy.
  always_comb begin
    free_any = 1'b0;
    free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!lvalid[idx_q][w]) begin
        free_any = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign victim = free_any ? free_way : pol_way;

`ifdef DCACHE_PLRU_EN
  // Tree bits are heap-ordered: node 0 is the root, children of n are
  // 2n+1 (lower half) and 2n+2 (upper half). A bit of 0 steers the victim
  // search toward the lower half.
  logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru;
  logic [NUM_WAYS-2:0]               plru_set;

  assign plru_set = plru[idx_q];

  function automatic logic [NUM_WAYS-2:0] plru_touch(
    input logic [NUM_WAYS-2:0] bits,
    input logic [WAY_W-1:0]    way
  );
    logic [NUM_WAYS-2:0] b;
    int                  n;
    b = bits;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      // Point away from the touched way at every node on its path.
      b[n] = ~way[WAY_W-1-l];
      n    = 2 * n + 1 + int'(way[WAY_W-1-l]);
    end
    return b;
  endfunction

  always_comb begin
    int node;
    node    = 0;
    pol_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      pol_way[WAY_W-1-l] = plru_set[node];
      node = 2 * node + 1 + int'(plru_set[node]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plru <= '0;
    end else if (state == S_LOOKUP && hit_any) begin
      plru[idx_q] <= plru_touch(plru_set, hit_way);
    end else if (state == S_FILL) begin
      plru[idx_q] <= plru_touch(plru_set, way_q);
    end
  end
`else
  // Round-robin only advances when the victim actually came from it, not
  // when a free way was used.
  logic [WAY_W-1:0] rr_cnt;
  logic             use_pol_q;

  assign pol_way = rr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_cnt    <= '0;
      use_pol_q <= 1'b0;
    end else begin
      if (state == S_LOOKUP) begin
        use_pol_q <= !free_any;
      end
      if (state == S_FILL && use_pol_q) begin
        rr_cnt <= rr_cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_hit          = 1'b0;
    rsp_way          = '0;
    ta_we            = 1'b0;
    ta_way           = '0;
    ta_tag_in        = '0;
    refill_req_valid = 1'b0;
    refill_req_addr  = '0;
    case (state)
      S_IDLE: begin
        // Gated by rst_n so ready stays low for the whole reset window.
        req_ready = rst_n;
        if (req_valid) begin
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_nxt = hit_any ? S_RESP : S_MISS_REQ;
      end
      S_MISS_REQ: begin
        refill_req_valid = 1'b1;
        refill_req_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (refill_req_ready) begin
          state_nxt = S_MISS_WAIT;
        end
      end
      S_MISS_WAIT: begin
        if (refill_done) begin
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        ta_we     = 1'b1;
        ta_way    = way_q;
        ta_tag_in = tag_q;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_way   = way_q;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign ta_index = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      idx_q  <= '0;
      way_q  <= '0;
      hit_q  <= 1'b0;
      lvalid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            tag_q <= req_addr[ADDR_W-1 -: TAG_W];
            idx_q <= req_addr[OFF_W +: IDX_W];
          end
        end
        S_LOOKUP: begin
          hit_q <= hit_any;
          way_q <= hit_any ? hit_way : victim;
        end
        S_FILL: begin
          lvalid[idx_q][way_q] <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_lookup_ctrl.sv
// Directed bench for dcache_lookup_ctrl with a behavioural tag array.
module tb_dcache_lookup_ctrl;
  localparam int TAG_W    = 20;
  localparam int NUM_SETS = 64;
  localparam int NUM_WAYS = 4;
  localparam int ADDR_W   = 32;
`ifdef DCACHE_PLRU_EN
  localparam int EVICT_WAY = 1;
`else
  localparam int EVICT_WAY = 0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [ADDR_W-1:0]         req_addr = '0;
  logic                      rsp_valid;
  logic                      rsp_hit;
  logic [1:0]                rsp_way;
  logic [5:0]                ta_index;
  logic [1:0]                ta_way;
  logic [TAG_W-1:0]          ta_tag_in;
  logic                      ta_we;
  logic [NUM_WAYS*TAG_W-1:0] ta_tag_out;
  logic [NUM_WAYS-1:0]       ta_valid_out;
  logic                      refill_req_valid;
  logic                      refill_req_ready = 1'b1;
  logic [ADDR_W-1:0]         refill_req_addr;
  logic                      refill_done = 1'b0;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  dcache_lookup_ctrl #(
    .TAG_W(TAG_W), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .ta_index(ta_index), .ta_way(ta_way), .ta_tag_in(ta_tag_in), .ta_we(ta_we),
    .ta_tag_out(ta_tag_out), .ta_valid_out(ta_valid_out),
    .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
    .refill_req_addr(refill_req_addr), .refill_done(refill_done)
  );

  // Tag array: not reset. Preloaded with tag 1 / valid in every entry so an
  // unmasked lookup of tag 1 would falsely hit.
  logic [TAG_W-1:0] tarr [NUM_SETS][NUM_WAYS];
  logic             tval [NUM_SETS][NUM_WAYS];
  logic             arr_init = 1'b1;

  always @(posedge clk) begin
    if (arr_init) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          tarr[s][w] = 20'h00001;
          tval[s][w] = 1'b1;
        end
      end
      arr_init = 1'b0;
    end else if (ta_we) begin
      tarr[ta_index][ta_way] = ta_tag_in;
      tval[ta_index][ta_way] = 1'b1;
    end
  end

  always_comb begin
    ta_tag_out   = '0;
    ta_valid_out = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      ta_tag_out[w*TAG_W +: TAG_W] = tarr[ta_index][w];
      ta_valid_out[w]              = tval[ta_index][w];
    end
  end

  int we_cnt = 0;
  int rsp_cnt = 0;
  int rreq_cnt = 0;

  always @(posedge clk) begin
    if (ta_we) we_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (refill_req_valid && refill_req_ready) rreq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the accepting edge (controller in LOOKUP).
  task automatic accept(input logic [31:0] a);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic miss_seq(input logic [31:0] a, input int exp_way, input int hold);
    if (hold > 0) refill_req_ready = 1'b0;
    accept(a);
    chk("miss_lookup_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      chk("hold_rreq_valid", {31'd0, refill_req_valid}, 32'd1);
      chk("hold_rreq_addr", refill_req_addr, {a[31:6], 6'b0});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("rreq_valid", {31'd0, refill_req_valid}, 32'd1);
    chk("rreq_addr", refill_req_addr, {a[31:6], 6'b0});
    refill_req_ready = 1'b1;
    @(negedge clk);
    chk("wait_rreq_low", {31'd0, refill_req_valid}, 32'd0);
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    chk("fill_we", {31'd0, ta_we}, 32'd1);
    chk("fill_index", {26'd0, ta_index}, {26'd0, a[11:6]});
    chk("fill_way", {30'd0, ta_way}, 32'(exp_way));
    chk("fill_tag", {12'd0, ta_tag_in}, {12'd0, a[31:12]});
    @(negedge clk);
    chk("miss_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("miss_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    chk("miss_rsp_way", {30'd0, rsp_way}, 32'(exp_way));
    chk("miss_we_done", {31'd0, ta_we}, 32'd0);
    @(negedge clk);
    chk("miss_back_idle", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic hit_seq(input logic [31:0] a, input int exp_way);
    int r0;
    r0 = rreq_cnt;
    accept(a);
    chk("hit_cycle1_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("hit_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("hit_rsp_hit", {31'd0, rsp_hit}, 32'd1);
    chk("hit_rsp_way", {30'd0, rsp_way}, 32'(exp_way));
    chk("hit_no_rreq", {31'd0, refill_req_valid}, 32'd0);
    @(negedge clk);
    chk("hit_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("hit_no_refill", 32'(rreq_cnt), 32'(r0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, rsp0;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rreq_valid", {31'd0, refill_req_valid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ta_we", {31'd0, ta_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Spurious refill_done in IDLE
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    @(negedge clk);
    chk("spur_req_ready", {31'd0, req_ready}, 32'd1);
    chk("spur_we_cnt", 32'(we_cnt), 32'd0);
    chk("spur_rsp_cnt", 32'(rsp_cnt), 32'd0);
    chk("spur_rreq", {31'd0, refill_req_valid}, 32'd0);

    // First access misses despite a matching unreset tag array entry
    miss_seq(32'h0000_1040, 0, 0);
    hit_seq(32'h0000_1040, 0);

    // Fill remaining ways of set 1; nonzero offset must be stripped
    miss_seq(32'h0000_2040, 1, 0);
    miss_seq(32'h0000_307C, 2, 0);
    miss_seq(32'h0000_4040, 3, 0);
    hit_seq(32'h0000_1040, 0);
    hit_seq(32'h0000_3040, 2);

    // Fifth tag with refill_req_ready held low for 10 cycles
    miss_seq(32'h0000_5040, EVICT_WAY, 10);
    hit_seq(32'h0000_5040, EVICT_WAY);

    // Reset in MISS_REQ: refill_req_valid drops without a clock edge
    refill_req_ready = 1'b0;
    accept(32'h0000_6080);
    @(negedge clk);
    chk("mreq_rreq_valid", {31'd0, refill_req_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rreq_drop", {31'd0, refill_req_valid}, 32'd0);
    chk("async_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    refill_req_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Reset in MISS_WAIT, then refill_done pulses: nothing may be written
    we0  = we_cnt;
    rsp0 = rsp_cnt;
    accept(32'h0000_7040);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    @(negedge clk);
    chk("rstwait_no_we", 32'(we_cnt), 32'(we0));
    chk("rstwait_no_rsp", 32'(rsp_cnt), 32'(rsp0));
    chk("rstwait_ready", {31'd0, req_ready}, 32'd1);

    // lvalid cleared: previously hitting line must miss into way 0
    miss_seq(32'h0000_1040, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
